// File: rtl/keyboard_controller.sv
// PS/2 keyboard receiver with a battleship-style coordinate entry FSM.
// Raw PS/2 lines are synchronised, the clock is glitch-filtered, frames are checked, and make codes drive entry.
module keyboard_controller #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 27000
) (
  input  logic       clock27,
  input  logic       resetN,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] keyboardData,
  output logic       byteValid,
  output logic       frameError,
  output logic [3:0] letter,
  output logic [3:0] number,
  output logic [1:0] entryState,
  output logic       coordValid
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TimeW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLetter = 2'd1,
    StReady  = 2'd2
  } state_e;

  logic             clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic             filt_q, filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall;

  logic [9:0]       shift_q, shift_d;
  logic [10:0]      frame_next;
  logic             frame_ok;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TimeW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]       kbd_q, kbd_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_error_q, frame_error_d;

  logic             dec_valid_q;
  logic [7:0]       dec_byte_q;
  logic             brk_q, brk_d, ext_q, ext_d;
  state_e           state_q, state_d;
  logic [3:0]       letter_q, letter_d, number_q, number_d;
  logic             coord_q, coord_d;

  logic             is_let, is_num, is_enter, is_bksp;
  logic [3:0]       let_code, num_code;

  // Level only follows the synchronised clock after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        fall   = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // frame_next[0] start, [8:1] data LSB first, [9] parity, [10] stop.
  assign frame_next = {data_s2_q, shift_q};
  assign frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);

  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    to_cnt_d      = '0;
    kbd_d         = kbd_q;
    byte_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    if (fall) begin
      shift_d = frame_next[10:1];
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (frame_ok) begin
          kbd_d        = frame_next[8:1];
          byte_valid_d = 1'b1;
        end else begin
          frame_error_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TimeW'(TIMEOUT - 1)) begin
        bit_cnt_d     = 4'd0;
        frame_error_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    is_let   = 1'b0;
    let_code = 4'hF;
    is_num   = 1'b0;
    num_code = 4'hF;
    is_enter = (dec_byte_q == 8'h5A);
    is_bksp  = (dec_byte_q == 8'h66);
    case (dec_byte_q)
      8'h1C: {is_let, let_code} = {1'b1, 4'd0};
      8'h32: {is_let, let_code} = {1'b1, 4'd1};
      8'h21: {is_let, let_code} = {1'b1, 4'd2};
      8'h23: {is_let, let_code} = {1'b1, 4'd3};
      8'h24: {is_let, let_code} = {1'b1, 4'd4};
      8'h2B: {is_let, let_code} = {1'b1, 4'd5};
      8'h34: {is_let, let_code} = {1'b1, 4'd6};
      8'h33: {is_let, let_code} = {1'b1, 4'd7};
      8'h43: {is_let, let_code} = {1'b1, 4'd8};
      8'h3B: {is_let, let_code} = {1'b1, 4'd9};
      8'h45: {is_num, num_code} = {1'b1, 4'd0};
      8'h16: {is_num, num_code} = {1'b1, 4'd1};
      8'h1E: {is_num, num_code} = {1'b1, 4'd2};
      8'h26: {is_num, num_code} = {1'b1, 4'd3};
      8'h25: {is_num, num_code} = {1'b1, 4'd4};
      8'h2E: {is_num, num_code} = {1'b1, 4'd5};
      8'h36: {is_num, num_code} = {1'b1, 4'd6};
      8'h3D: {is_num, num_code} = {1'b1, 4'd7};
      8'h3E: {is_num, num_code} = {1'b1, 4'd8};
      8'h46: {is_num, num_code} = {1'b1, 4'd9};
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    letter_d = letter_q;
    number_d = number_q;
    coord_d  = 1'b0;
    brk_d    = brk_q;
    ext_d    = ext_q;
    if (dec_valid_q) begin
      if (dec_byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (dec_byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q || ext_q) begin
        // Byte following a prefix (break or extended) is swallowed.
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (is_let) begin
              letter_d = let_code;
              number_d = 4'hF;
              state_d  = StLetter;
            end
          end
          StLetter: begin
            if (is_let) begin
              letter_d = let_code;
            end else if (is_num) begin
              number_d = num_code;
              state_d  = StReady;
            end else if (is_bksp) begin
              letter_d = 4'hF;
              state_d  = StIdle;
            end
          end
          StReady: begin
            if (is_num) begin
              number_d = num_code;
            end else if (is_bksp) begin
              number_d = 4'hF;
              state_d  = StLetter;
            end else if (is_enter) begin
              coord_d = 1'b1;
              state_d = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clock27) begin
    if (!resetN) begin
      clk_s1_q      <= 1'b1;
      clk_s2_q      <= 1'b1;
      data_s1_q     <= 1'b1;
      data_s2_q     <= 1'b1;
      filt_q        <= 1'b1;
      filt_cnt_q    <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= 4'd0;
      to_cnt_q      <= '0;
      kbd_q         <= 8'h00;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      dec_valid_q   <= 1'b0;
      dec_byte_q    <= 8'h00;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      state_q       <= StIdle;
      letter_q      <= 4'hF;
      number_q      <= 4'hF;
      coord_q       <= 1'b0;
    end else begin
      clk_s1_q      <= ps2Clk;
      clk_s2_q      <= clk_s1_q;
      data_s1_q     <= ps2Data;
      data_s2_q     <= data_s1_q;
      filt_q        <= filt_d;
      filt_cnt_q    <= filt_cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      to_cnt_q      <= to_cnt_d;
      kbd_q         <= kbd_d;
      byte_valid_q  <= byte_valid_d;
      frame_error_q <= frame_error_d;
      dec_valid_q   <= byte_valid_q;
      dec_byte_q    <= kbd_q;
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      state_q       <= state_d;
      letter_q      <= letter_d;
      number_q      <= number_d;
      coord_q       <= coord_d;
    end
  end

  assign keyboardData = kbd_q;
  assign byteValid    = byte_valid_q;
  assign frameError   = frame_error_q;
  assign letter       = letter_q;
  assign number       = number_q;
  assign entryState   = state_q;
  assign coordValid   = coord_q;

endmodule

// File: tb/tb_keyboard_controller.sv
// Directed bench for keyboard_controller: table of PS/2 frames with expected outputs,
// plus timeout and mid-frame reset sequences.
module tb_keyboard_controller;

  localparam int unsigned FiltLen = 4;
  localparam int unsigned Timeout = 200;

  logic       clock27 = 1'b0;
  logic       resetN  = 1'b0;
  logic       ps2Clk  = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] keyboardData;
  logic       byteValid, frameError, coordValid;
  logic [3:0] letter, number;
  logic [1:0] entryState;

  keyboard_controller #(
    .FILTER_LEN(FiltLen),
    .TIMEOUT   (Timeout)
  ) dut (
    .clock27     (clock27),
    .resetN      (resetN),
    .ps2Clk      (ps2Clk),
    .ps2Data     (ps2Data),
    .keyboardData(keyboardData),
    .byteValid   (byteValid),
    .frameError  (frameError),
    .letter      (letter),
    .number      (number),
    .entryState  (entryState),
    .coordValid  (coordValid)
  );

  always #5 clock27 = ~clock27;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, bv_cycles = 0, fe_cycles = 0, cv_cycles = 0, both_cycles = 0;
  int last_bv_cyc = 0, last_cv_cyc = 0;

  // Pulse widths are accumulated as high cycles, so a delta of 1 means one single-cycle pulse.
  always @(negedge clock27) begin
    cyc <= cyc + 1;
    if (byteValid) begin
      bv_cycles   <= bv_cycles + 1;
      last_bv_cyc <= cyc;
    end
    if (frameError) fe_cycles <= fe_cycles + 1;
    if (coordValid) begin
      cv_cycles   <= cv_cycles + 1;
      last_cv_cyc <= cyc;
    end
    if (byteValid && frameError) both_cycles <= both_cycles + 1;
  end

  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [7:0] kbd;
    int         bv;
    int         fe;
    logic [3:0] ltr;
    logic [3:0] nbr;
    logic [1:0] st;
    int         cv;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock27);
  endtask

  task automatic send_bits(input logic [7:0] d, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2Data = f[i];
      wait_cyc(5);
      ps2Clk = 1'b0;
      wait_cyc(10);
      ps2Clk = 1'b1;
      wait_cyc(5);
    end
    ps2Data = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_kbd"}, 32'(keyboardData), 32'h00);
    check({tag, "_bv"}, 32'(byteValid), 32'h0);
    check({tag, "_fe"}, 32'(frameError), 32'h0);
    check({tag, "_letter"}, 32'(letter), 32'hF);
    check({tag, "_number"}, 32'(number), 32'hF);
    check({tag, "_state"}, 32'(entryState), 32'h0);
    check({tag, "_cv"}, 32'(coordValid), 32'h0);
  endtask

  initial begin
    int bv0, fe0, cv0;

    vecs[0]  = '{8'h1C, 1'b0, 8'h1C, 1, 0, 4'h0, 4'hF, 2'd1, 0};
    vecs[1]  = '{8'h16, 1'b0, 8'h16, 1, 0, 4'h0, 4'h1, 2'd2, 0};
    vecs[2]  = '{8'h5A, 1'b0, 8'h5A, 1, 0, 4'h0, 4'h1, 2'd0, 1};
    vecs[3]  = '{8'h1C, 1'b0, 8'h1C, 1, 0, 4'h0, 4'hF, 2'd1, 0};
    vecs[4]  = '{8'hF0, 1'b0, 8'hF0, 1, 0, 4'h0, 4'hF, 2'd1, 0};
    vecs[5]  = '{8'h1C, 1'b0, 8'h1C, 1, 0, 4'h0, 4'hF, 2'd1, 0};
    vecs[6]  = '{8'h16, 1'b0, 8'h16, 1, 0, 4'h0, 4'h1, 2'd2, 0};
    vecs[7]  = '{8'h16, 1'b1, 8'h16, 0, 1, 4'h0, 4'h1, 2'd2, 0};
    vecs[8]  = '{8'h66, 1'b0, 8'h66, 1, 0, 4'h0, 4'hF, 2'd1, 0};
    vecs[9]  = '{8'h66, 1'b0, 8'h66, 1, 0, 4'hF, 4'hF, 2'd0, 0};
    vecs[10] = '{8'hE0, 1'b0, 8'hE0, 1, 0, 4'hF, 4'hF, 2'd0, 0};
    vecs[11] = '{8'h1C, 1'b0, 8'h1C, 1, 0, 4'hF, 4'hF, 2'd0, 0};
    vecs[12] = '{8'h32, 1'b0, 8'h32, 1, 0, 4'h1, 4'hF, 2'd1, 0};
    vecs[13] = '{8'h3B, 1'b0, 8'h3B, 1, 0, 4'h9, 4'hF, 2'd1, 0};
    vecs[14] = '{8'h5A, 1'b0, 8'h5A, 1, 0, 4'h9, 4'hF, 2'd1, 0};
    vecs[15] = '{8'h46, 1'b0, 8'h46, 1, 0, 4'h9, 4'h9, 2'd2, 0};
    vecs[16] = '{8'h2B, 1'b0, 8'h2B, 1, 0, 4'h9, 4'h9, 2'd2, 0};
    vecs[17] = '{8'h5A, 1'b0, 8'h5A, 1, 0, 4'h9, 4'h9, 2'd0, 1};
    vecs[18] = '{8'h99, 1'b0, 8'h99, 1, 0, 4'h9, 4'h9, 2'd0, 0};

    wait_cyc(5);
    check_reset_outputs("reset");
    resetN = 1'b1;
    wait_cyc(5);

    for (int i = 0; i < 19; i++) begin
      bv0 = bv_cycles;
      fe0 = fe_cycles;
      cv0 = cv_cycles;
      send_bits(vecs[i].code, vecs[i].bad, 11);
      wait_cyc(20);
      check($sformatf("v%0d_kbd", i), 32'(keyboardData), 32'(vecs[i].kbd));
      check($sformatf("v%0d_bv", i), 32'(bv_cycles - bv0), 32'(vecs[i].bv));
      check($sformatf("v%0d_fe", i), 32'(fe_cycles - fe0), 32'(vecs[i].fe));
      check($sformatf("v%0d_letter", i), 32'(letter), 32'(vecs[i].ltr));
      check($sformatf("v%0d_number", i), 32'(number), 32'(vecs[i].nbr));
      check($sformatf("v%0d_state", i), 32'(entryState), 32'(vecs[i].st));
      check($sformatf("v%0d_cv", i), 32'(cv_cycles - cv0), 32'(vecs[i].cv));
      if (vecs[i].cv != 0) begin
        check($sformatf("v%0d_cv_latency", i), 32'(last_cv_cyc - last_bv_cyc), 32'd2);
      end
    end

    // Partial frame then idle: one abort, no repeat, then a clean frame decodes.
    bv0 = bv_cycles;
    fe0 = fe_cycles;
    send_bits(8'h45, 1'b0, 6);
    wait_cyc(Timeout + 40);
    check("timeout_fe", 32'(fe_cycles - fe0), 32'd1);
    check("timeout_bv", 32'(bv_cycles - bv0), 32'd0);
    check("timeout_kbd_held", 32'(keyboardData), 32'h99);
    wait_cyc(Timeout + 40);
    check("timeout_once", 32'(fe_cycles - fe0), 32'd1);
    send_bits(8'h45, 1'b0, 11);
    wait_cyc(20);
    check("after_timeout_kbd", 32'(keyboardData), 32'h45);
    check("after_timeout_bv", 32'(bv_cycles - bv0), 32'd1);
    check("after_timeout_state", 32'(entryState), 32'd0);

    fe0 = fe_cycles;
    send_bits(8'h16, 1'b1, 11);
    wait_cyc(20);
    check("bad_parity_kbd_held", 32'(keyboardData), 32'h45);
    check("bad_parity_fe", 32'(fe_cycles - fe0), 32'd1);

    // Letter after a confirm clears the held number.
    send_bits(8'h1C, 1'b0, 11);
    wait_cyc(20);
    check("post_confirm_letter", 32'(letter), 32'h0);
    check("post_confirm_number", 32'(number), 32'hF);
    check("post_confirm_state", 32'(entryState), 32'd1);

    // Reset after bit 5 of a frame.
    fe0 = fe_cycles;
    send_bits(8'h45, 1'b0, 6);
    resetN = 1'b0;
    wait_cyc(3);
    resetN = 1'b1;
    wait_cyc(2);
    check_reset_outputs("midreset");
    wait_cyc(Timeout + 40);
    check("midreset_no_fe", 32'(fe_cycles - fe0), 32'd0);
    bv0 = bv_cycles;
    send_bits(8'h45, 1'b0, 11);
    wait_cyc(20);
    check("midreset_next_kbd", 32'(keyboardData), 32'h45);
    check("midreset_next_bv", 32'(bv_cycles - bv0), 32'd1);
    check("midreset_next_state", 32'(entryState), 32'd0);
    check("midreset_next_letter", 32'(letter), 32'hF);

    check("bv_fe_exclusive", 32'(both_cycles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
